gpio_bank: RTL

Parametrised multi-port GPIO peripheral, successor to the fixed single-output/single-input port pair on the chip's GPIO design. Provides NPORTS ports of WIDTH bits, each pin with individual direction, atomic set/clear/toggle writes, input synchronisation and per-pin rising/falling-edge interrupt flags. Sits behind the design's synchronous register bus (decoded from the external CEb/OEb/WEb interface), and drives the bidirectional pad enables through chip_top.

---
 rtl/gpio_pkg.sv | 14 +
 rtl/gpio_sync_edge.sv | 59 +++++
 rtl/gpio_bank.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// gpio_bank register map shared by the bank and its bench.
// No logic; offsets index the low nibble of the bus address.
package gpio_pkg;
   localparam int         REG_IDX_W = 4;
   localparam logic [3:0] REG_OUT   = 4'd0;
   localparam logic [3:0] REG_DIR   = 4'd1;
   localparam logic [3:0] REG_IN    = 4'd2;
   localparam logic [3:0] REG_SET   = 4'd3;
   localparam logic [3:0] REG_CLR   = 4'd4;
   localparam logic [3:0] REG_TGL   = 4'd5;
   localparam logic [3:0] REG_RISE  = 4'd6;
   localparam logic [3:0] REG_FALL  = 4'd7;
   localparam logic [3:0] REG_IFLAG = 4'd8;
endpackage

// File: rtl/gpio_sync_edge.sv
// Pin-vector synchroniser, optional tick-sampled debounce (GPIO_DEBOUNCE_EN), edge detect.
// Latency: pin to o_in 2 cycles (+ up to 3 ticks debounced); no backpressure.
module gpio_sync_edge #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
`ifdef GPIO_DEBOUNCE_EN
   input  logic             i_tick,
`endif
   input  logic [WIDTH-1:0] i_pin,
   output logic [WIDTH-1:0] o_in,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall
);
   logic [WIDTH-1:0] r_s1, r_s2, r_p, w_f;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_pin;
         r_s2 <= r_s1;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   logic [WIDTH-1:0] r_h1, r_h2, r_f, w_stable;

   // A bit is accepted only once three consecutive tick samples agree.
   assign w_stable = ~(r_s2 ^ r_h1) & ~(r_h1 ^ r_h2);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_h1 <= '0;
         r_h2 <= '0;
         r_f  <= '0;
      end else if (i_tick) begin
         r_h1 <= r_s2;
         r_h2 <= r_h1;
         r_f  <= (w_stable & r_s2) | (~w_stable & r_f);
      end
   end

   assign w_f = r_f;
`else
   assign w_f = r_s2;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_p <= '0;
      else       r_p <= w_f;
   end

   assign o_in   = w_f;
   assign o_rise = w_f & ~r_p;
   assign o_fall = ~w_f & r_p;
endmodule

// File: rtl/gpio_bank.sv
// NPORTS x WIDTH GPIO bank: set/clr/tgl writes, synchronised inputs, w1c edge flags (GPIO_DEBOUNCE_EN adds debounce).
// Latency: writes take effect next edge, rdata registered one cycle after re; no backpressure.
module gpio_bank
   import gpio_pkg::*;
#(
   parameter int NPORTS = 2,
   parameter int WIDTH  = 8
`ifdef GPIO_DEBOUNCE_EN
   ,
   parameter int DB_DIV = 16
`endif
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [$clog2(NPORTS)+3:0]   i_addr,
   input  logic                        i_we,
   input  logic                        i_re,
   input  logic [WIDTH-1:0]            i_wdata,
   output logic [WIDTH-1:0]            o_rdata,
   input  logic [NPORTS*WIDTH-1:0]     i_pin,
   output logic [NPORTS*WIDTH-1:0]     o_pin,
   output logic [NPORTS*WIDTH-1:0]     o_pin_oe,
   output logic                        o_irq
);
   logic [7:0]                    w_port;
   logic [3:0]                    w_reg;
   logic [NPORTS-1:0][WIDTH-1:0]  w_rd_port;
   logic [NPORTS-1:0]             w_port_irq;
   logic [WIDTH-1:0]              w_rd_val;
   logic [WIDTH-1:0]              r_rdata;

   assign w_port = 8'(i_addr >> REG_IDX_W);
   assign w_reg  = i_addr[3:0];

`ifdef GPIO_DEBOUNCE_EN
   localparam int PW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
   logic [PW-1:0] r_pre;
   logic          w_tick;

   assign w_tick = (r_pre == PW'(DB_DIV - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       r_pre <= '0;
      else if (w_tick) r_pre <= '0;
      else             r_pre <= r_pre + 1'b1;
   end
`endif

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      logic             w_sel;
      logic [WIDTH-1:0] w_in, w_rise, w_fall, w_w1c, w_set_ev, w_rd_word;
      logic [WIDTH-1:0] r_out, r_dir, r_rise, r_fall, r_iflag;

      assign w_sel = (w_port == 8'(p));

      gpio_sync_edge #(.WIDTH(WIDTH)) u_sync (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
`ifdef GPIO_DEBOUNCE_EN
         .i_tick (w_tick),
`endif
         .i_pin  (i_pin[p*WIDTH +: WIDTH]),
         .o_in   (w_in),
         .o_rise (w_rise),
         .o_fall (w_fall)
      );

      // Set term is ORed after the clear so a coincident event beats the w1c.
      assign w_set_ev = (w_rise & r_rise) | (w_fall & r_fall);
      assign w_w1c    = (i_we && w_sel && w_reg == REG_IFLAG) ? i_wdata : '0;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_out   <= '0;
            r_dir   <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_iflag <= '0;
         end else begin
            r_iflag <= (r_iflag & ~w_w1c) | w_set_ev;
            if (i_we && w_sel) begin
               case (w_reg)
                  REG_OUT:  r_out  <= i_wdata;
                  REG_DIR:  r_dir  <= i_wdata;
                  REG_SET:  r_out  <= r_out | i_wdata;
                  REG_CLR:  r_out  <= r_out & ~i_wdata;
                  REG_TGL:  r_out  <= r_out ^ i_wdata;
                  REG_RISE: r_rise <= i_wdata;
                  REG_FALL: r_fall <= i_wdata;
                  default:  ;
               endcase
            end
         end
      end

      always_comb begin
         w_rd_word = '0;
         case (w_reg)
            REG_OUT:   w_rd_word = r_out;
            REG_DIR:   w_rd_word = r_dir;
            REG_IN:    w_rd_word = w_in;
            REG_RISE:  w_rd_word = r_rise;
            REG_FALL:  w_rd_word = r_fall;
            REG_IFLAG: w_rd_word = r_iflag;
            default:   w_rd_word = '0;
         endcase
      end

      assign w_rd_port[p]               = w_rd_word;
      assign w_port_irq[p]              = |r_iflag;
      assign o_pin[p*WIDTH +: WIDTH]    = r_out;
      assign o_pin_oe[p*WIDTH +: WIDTH] = r_dir;
   end

   always_comb begin
      w_rd_val = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (w_port == 8'(p)) w_rd_val = w_rd_port[p];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     r_rdata <= '0;
      else if (i_re) r_rdata <= w_rd_val;
   end

   assign o_rdata = r_rdata;
   assign o_irq   = |w_port_irq;
endmodule
